// File: rtl/ysyx_24100005_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_mem_arbiter
// Brief    : Shares one memory port between IFU (read) and LSU (read/write),
//            one transaction in flight, round-robin on simultaneous requests.
// Revision : 1.0
// ============================================================================
module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                grant_lsu
);

    localparam int c_MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    // Last grant and current owner are the same fact, so one register holds both.
    logic                r_last_lsu;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_MASK_W-1:0] r_wmask;

    logic w_idle;
    logic w_resp;
    logic w_pick_lsu;
    logic w_ifu_hs;
    logic w_lsu_hs;

    // Handshake outputs are forced low while reset is held.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_resp     = (r_state == ST_RESP) && !rst;
    assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);

    assign lsu_req_ready = w_idle && w_pick_lsu;
    assign ifu_req_ready = w_idle && ifu_req_valid && !w_pick_lsu;
    assign w_ifu_hs      = ifu_req_valid && ifu_req_ready;
    assign w_lsu_hs      = lsu_req_valid && lsu_req_ready;

    assign mem_req_valid  = (r_state == ST_REQ) && !rst;
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign mem_resp_ready = w_resp && (r_last_lsu ? lsu_resp_ready : ifu_resp_ready);

    assign ifu_resp_valid = w_resp && !r_last_lsu && mem_resp_valid;
    assign lsu_resp_valid = w_resp &&  r_last_lsu && mem_resp_valid;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;
    assign grant_lsu      = r_last_lsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_lsu <= 1'b0;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lsu_hs) begin
                        r_addr     <= lsu_addr;
                        r_wen      <= lsu_wen;
                        r_wdata    <= lsu_wdata;
                        r_wmask    <= lsu_wmask;
                        r_last_lsu <= 1'b1;
                        r_state    <= ST_REQ;
                    end else if (w_ifu_hs) begin
                        r_addr     <= ifu_addr;
                        r_wen      <= 1'b0;
                        r_wdata    <= '0;
                        r_wmask    <= '0;
                        r_last_lsu <= 1'b0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid && mem_resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
